// File: rtl/axi4_stream_ratio_upsizer_if.sv
// AXI4-Stream bundle shared by the upsizer's narrow and wide sides.
// Field widths are set per instance so each side carries its own widths.
interface axi4_stream_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 1
);
    logic                    tvalid;
    logic                    tready;
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic                    tlast;
    logic [ID_WIDTH-1:0]     tid;
    logic [DEST_WIDTH-1:0]   tdest;
    logic [USER_WIDTH-1:0]   tuser;

    modport master (
        output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/axi4_stream_ratio_upsizer.sv
// Packet-aware AXI4-Stream upsizer: packs RATIO narrow beats into one registered wide beat.
// Optional AXI4_STREAM_RATIO_UPSIZER_TUSER_PACK_EN carries per-lane tuser instead of first-beat tuser.
module axi4_stream_ratio_upsizer #(
    parameter int RX_TDATA_WIDTH = 16,
    parameter int RATIO          = 4,
    parameter int TID_WIDTH      = 1,
    parameter int TDEST_WIDTH    = 1,
    parameter int TUSER_WIDTH    = 1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    axi4_stream_if.slave  pkt_i,
    axi4_stream_if.master pkt_o
);
    localparam int TX_TDATA_WIDTH = RATIO * RX_TDATA_WIDTH;
    localparam int RX_KW          = RX_TDATA_WIDTH / 8;
    localparam int TX_KW          = TX_TDATA_WIDTH / 8;
    localparam int LANE_W         = (RATIO > 1) ? $clog2(RATIO) : 1;
`ifdef AXI4_STREAM_RATIO_UPSIZER_TUSER_PACK_EN
    localparam int OUT_TUSER_W    = RATIO * TUSER_WIDTH;
`else
    localparam int OUT_TUSER_W    = TUSER_WIDTH;
`endif
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

    if ((RX_TDATA_WIDTH % 8) != 0) begin : g_bad_width
        $error("RX_TDATA_WIDTH must be a multiple of 8");
    end
    if (RATIO < 1) begin : g_bad_ratio
        $error("RATIO must be >= 1");
    end

    logic [TX_TDATA_WIDTH-1:0] acc_data, acc_data_n, mrg_data, fresh_data;
    logic [TX_KW-1:0]          acc_keep, acc_keep_n, mrg_keep, fresh_keep;
    logic [TX_KW-1:0]          acc_strb, acc_strb_n, mrg_strb, fresh_strb;
    logic [OUT_TUSER_W-1:0]    acc_user, acc_user_n, mrg_user, fresh_user;
    logic [TID_WIDTH-1:0]      acc_tid, acc_tid_n, mrg_tid;
    logic [TDEST_WIDTH-1:0]    acc_tdest, acc_tdest_n, mrg_tdest;
    logic [LANE_W-1:0]         lane, lane_n;
    logic                      acc_busy, acc_busy_n, pend, pend_n;

    logic                      out_valid, out_valid_n, out_last, out_last_n;
    logic [TX_TDATA_WIDTH-1:0] out_data, out_data_n;
    logic [TX_KW-1:0]          out_keep, out_keep_n, out_strb, out_strb_n;
    logic [TID_WIDTH-1:0]      out_tid, out_tid_n;
    logic [TDEST_WIDTH-1:0]    out_tdest, out_tdest_n;
    logic [OUT_TUSER_W-1:0]    out_user, out_user_n;

    logic        out_free, rx_ready, rx_hs, tx_hs, stream_switch;
    int unsigned lane_idx;

    always_comb begin
        out_free      = !out_valid || pkt_o.tready;
        rx_ready      = out_free && !pend;
        rx_hs         = pkt_i.tvalid && rx_ready;
        tx_hs         = out_valid && pkt_o.tready;
        lane_idx      = 32'(lane);
        stream_switch = (RATIO > 1) && acc_busy &&
                        ({pkt_i.tid, pkt_i.tdest} != {acc_tid, acc_tdest});

        // Current beat merged into the accumulator, and as lane 0 of an empty word
        mrg_data = acc_data;
        mrg_keep = acc_keep;
        mrg_strb = acc_strb;
        mrg_data[lane_idx*RX_TDATA_WIDTH +: RX_TDATA_WIDTH] = pkt_i.tdata;
        mrg_keep[lane_idx*RX_KW +: RX_KW] = pkt_i.tkeep;
        mrg_strb[lane_idx*RX_KW +: RX_KW] = pkt_i.tstrb;
        fresh_data = '0;
        fresh_keep = '0;
        fresh_strb = '0;
        fresh_data[RX_TDATA_WIDTH-1:0] = pkt_i.tdata;
        fresh_keep[RX_KW-1:0] = pkt_i.tkeep;
        fresh_strb[RX_KW-1:0] = pkt_i.tstrb;
`ifdef AXI4_STREAM_RATIO_UPSIZER_TUSER_PACK_EN
        mrg_user = acc_user;
        mrg_user[lane_idx*TUSER_WIDTH +: TUSER_WIDTH] = pkt_i.tuser;
        fresh_user = '0;
        fresh_user[TUSER_WIDTH-1:0] = pkt_i.tuser;
`else
        mrg_user   = acc_busy ? acc_user : pkt_i.tuser;
        fresh_user = pkt_i.tuser;
`endif
        mrg_tid   = acc_busy ? acc_tid : pkt_i.tid;
        mrg_tdest = acc_busy ? acc_tdest : pkt_i.tdest;

        acc_data_n  = acc_data;
        acc_keep_n  = acc_keep;
        acc_strb_n  = acc_strb;
        acc_user_n  = acc_user;
        acc_tid_n   = acc_tid;
        acc_tdest_n = acc_tdest;
        lane_n      = lane;
        acc_busy_n  = acc_busy;
        pend_n      = pend;
        out_valid_n = out_valid;
        out_data_n  = out_data;
        out_keep_n  = out_keep;
        out_strb_n  = out_strb;
        out_last_n  = out_last;
        out_tid_n   = out_tid;
        out_tdest_n = out_tdest;
        out_user_n  = out_user;

        if (tx_hs) out_valid_n = 1'b0;

        if (pend || (rx_hs && stream_switch)) begin
            // Both cases emit the accumulator as-is; a pending word is always a packet end
            if (out_free) begin
                out_valid_n = 1'b1;
                out_data_n  = acc_data;
                out_keep_n  = acc_keep;
                out_strb_n  = acc_strb;
                out_last_n  = pend;
                out_tid_n   = acc_tid;
                out_tdest_n = acc_tdest;
                out_user_n  = acc_user;
                acc_data_n  = '0;
                acc_keep_n  = '0;
                acc_strb_n  = '0;
                acc_user_n  = '0;
                lane_n      = '0;
                acc_busy_n  = 1'b0;
                pend_n      = 1'b0;
            end
            if (!pend) begin
                acc_data_n  = fresh_data;
                acc_keep_n  = fresh_keep;
                acc_strb_n  = fresh_strb;
                acc_user_n  = fresh_user;
                acc_tid_n   = pkt_i.tid;
                acc_tdest_n = pkt_i.tdest;
                acc_busy_n  = 1'b1;
                pend_n      = pkt_i.tlast;
                lane_n      = pkt_i.tlast ? '0 : LANE_W'(1);
            end
        end else if (rx_hs) begin
            if (lane == LAST_LANE || pkt_i.tlast) begin
                out_valid_n = 1'b1;
                out_data_n  = mrg_data;
                out_keep_n  = mrg_keep;
                out_strb_n  = mrg_strb;
                out_last_n  = pkt_i.tlast;
                out_tid_n   = mrg_tid;
                out_tdest_n = mrg_tdest;
                out_user_n  = mrg_user;
                acc_data_n  = '0;
                acc_keep_n  = '0;
                acc_strb_n  = '0;
                acc_user_n  = '0;
                lane_n      = '0;
                acc_busy_n  = 1'b0;
            end else begin
                acc_data_n  = mrg_data;
                acc_keep_n  = mrg_keep;
                acc_strb_n  = mrg_strb;
                acc_user_n  = mrg_user;
                acc_tid_n   = mrg_tid;
                acc_tdest_n = mrg_tdest;
                lane_n      = lane + 1'b1;
                acc_busy_n  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_data  <= '0;
            acc_keep  <= '0;
            acc_strb  <= '0;
            acc_user  <= '0;
            acc_tid   <= '0;
            acc_tdest <= '0;
            lane      <= '0;
            acc_busy  <= 1'b0;
            pend      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_strb  <= '0;
            out_last  <= 1'b0;
            out_tid   <= '0;
            out_tdest <= '0;
            out_user  <= '0;
        end else begin
            acc_data  <= acc_data_n;
            acc_keep  <= acc_keep_n;
            acc_strb  <= acc_strb_n;
            acc_user  <= acc_user_n;
            acc_tid   <= acc_tid_n;
            acc_tdest <= acc_tdest_n;
            lane      <= lane_n;
            acc_busy  <= acc_busy_n;
            pend      <= pend_n;
            out_valid <= out_valid_n;
            out_data  <= out_data_n;
            out_keep  <= out_keep_n;
            out_strb  <= out_strb_n;
            out_last  <= out_last_n;
            out_tid   <= out_tid_n;
            out_tdest <= out_tdest_n;
            out_user  <= out_user_n;
        end
    end

    assign pkt_i.tready = rx_ready;
    assign pkt_o.tvalid = out_valid;
    assign pkt_o.tdata  = out_data;
    assign pkt_o.tkeep  = out_keep;
    assign pkt_o.tstrb  = out_strb;
    assign pkt_o.tlast  = out_last;
    assign pkt_o.tid    = out_tid;
    assign pkt_o.tdest  = out_tdest;
    assign pkt_o.tuser  = out_user;
endmodule

// File: tb/tb_axi4_stream_ratio_upsizer.sv
// Directed bench for axi4_stream_ratio_upsizer at RATIO=4, 16-bit input.
// Honours AXI4_STREAM_RATIO_UPSIZER_TUSER_PACK_EN for the tuser expectation.
module tb_axi4_stream_ratio_upsizer;
`ifdef AXI4_STREAM_RATIO_UPSIZER_TUSER_PACK_EN
    localparam int OUT_TU = 4;
    localparam logic [OUT_TU-1:0] T6_USER = 4'b1101;
`else
    localparam int OUT_TU = 1;
    localparam logic [OUT_TU-1:0] T6_USER = 1'b1;
`endif

    logic clk = 1'b0;
    logic rst_n;

    axi4_stream_if #(.DATA_WIDTH(16), .ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(1)) rx_if ();
    axi4_stream_if #(.DATA_WIDTH(64), .ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(OUT_TU)) tx_if ();

    axi4_stream_ratio_upsizer #(
        .RX_TDATA_WIDTH(16),
        .RATIO(4),
        .TID_WIDTH(1),
        .TDEST_WIDTH(1),
        .TUSER_WIDTH(1)
    ) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .pkt_i(rx_if),
        .pkt_o(tx_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0]       data;
        logic [7:0]        keep;
        logic [7:0]        strb;
        logic              last;
        logic              tid;
        logic [OUT_TU-1:0] user;
    } word_t;

    word_t got_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output monitor: collect handshaken words, and hold fields stable across stalls
    logic [127:0] tx_snap;
    logic [127:0] stall_snap = '0;
    logic         have_stall = 1'b0;
    assign tx_snap = 128'({tx_if.tvalid, tx_if.tlast, tx_if.tid, tx_if.tdest, tx_if.tuser,
                           tx_if.tkeep, tx_if.tstrb, tx_if.tdata});

    always @(negedge clk) begin
        if (!rst_n) begin
            have_stall <= 1'b0;
        end else begin
            if (have_stall) check_eq("hold_stable", tx_snap, stall_snap);
            have_stall <= tx_if.tvalid && !tx_if.tready;
            stall_snap <= tx_snap;
            if (tx_if.tvalid && tx_if.tready)
                got_q.push_back('{data: tx_if.tdata, keep: tx_if.tkeep, strb: tx_if.tstrb,
                                  last: tx_if.tlast, tid: tx_if.tid, user: tx_if.tuser});
        end
    end

    task automatic send(input logic [15:0] d, input logic [1:0] k, input logic last,
                        input logic id, input logic u);
        int unsigned waited = 0;
        rx_if.tvalid = 1'b1;
        rx_if.tdata  = d;
        rx_if.tkeep  = k;
        rx_if.tstrb  = k;
        rx_if.tlast  = last;
        rx_if.tid    = id;
        rx_if.tdest  = 1'b0;
        rx_if.tuser  = u;
        @(negedge clk);
        while (!rx_if.tready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!rx_if.tready) check_eq("rx_accept", 128'(rx_if.tready), 128'(1'b1));
        @(posedge clk);
        #1;
        rx_if.tvalid = 1'b0;
        rx_if.tlast  = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [63:0] d, input logic [7:0] k,
                               input logic last, input logic id, input logic [OUT_TU-1:0] u);
        word_t w;
        int unsigned waited = 0;
        while (got_q.size() == 0 && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (got_q.size() == 0) begin
            check_eq({tag, ".count"}, 128'(got_q.size()), 128'(1));
        end else begin
            w = got_q.pop_front();
            check_eq({tag, ".data"}, 128'(w.data), 128'(d));
            check_eq({tag, ".keep"}, 128'(w.keep), 128'(k));
            check_eq({tag, ".strb"}, 128'(w.strb), 128'(k));
            check_eq({tag, ".last"}, 128'(w.last), 128'(last));
            check_eq({tag, ".tid"},  128'(w.tid),  128'(id));
            check_eq({tag, ".user"}, 128'(w.user), 128'(u));
        end
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [19:0] ready_pat;

    initial begin
        rst_n        = 1'b0;
        rx_if.tvalid = 1'b0;
        rx_if.tdata  = '0;
        rx_if.tkeep  = '0;
        rx_if.tstrb  = '0;
        rx_if.tlast  = 1'b0;
        rx_if.tid    = 1'b0;
        rx_if.tdest  = 1'b0;
        rx_if.tuser  = 1'b0;
        tx_if.tready = 1'b1;
        idle(3);
        check_eq("rst.tvalid", 128'(tx_if.tvalid), 128'(1'b0));
        check_eq("rst.tdata",  128'(tx_if.tdata),  128'(64'h0));
        check_eq("rst.tkeep",  128'(tx_if.tkeep),  128'(8'h0));
        check_eq("rst.tlast",  128'(tx_if.tlast),  128'(1'b0));
        check_eq("rst.tready", 128'(rx_if.tready), 128'(1'b1));
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // Two full words from an 8-beat packet
        for (int i = 1; i <= 8; i++) send(16'(i), 2'b11, i == 8, 1'b0, 1'b0);
        expect_word("t1w0", 64'h0004_0003_0002_0001, 8'hFF, 1'b0, 1'b0, '0);
        expect_word("t1w1", 64'h0008_0007_0006_0005, 8'hFF, 1'b1, 1'b0, '0);

        // Short packet flushed early on tlast
        send(16'h000A, 2'b11, 1'b0, 1'b0, 1'b0);
        send(16'h000B, 2'b11, 1'b0, 1'b0, 1'b0);
        send(16'h000C, 2'b01, 1'b1, 1'b0, 1'b0);
        expect_word("t2", 64'h0000_000C_000B_000A, 8'b0001_1111, 1'b1, 1'b0, '0);

        // tid change mid-word
        send(16'h0001, 2'b11, 1'b0, 1'b0, 1'b0);
        send(16'h0002, 2'b11, 1'b0, 1'b0, 1'b0);
        for (int i = 3; i <= 6; i++) send(16'(i), 2'b11, i == 6, 1'b1, 1'b0);
        expect_word("t3w0", 64'h0000_0000_0002_0001, 8'h0F, 1'b0, 1'b0, '0);
        expect_word("t3w1", 64'h0006_0005_0004_0003, 8'hFF, 1'b1, 1'b1, '0);

        // tid change on a tlast beat: the new beat is a complete word on its own
        send(16'h0031, 2'b11, 1'b0, 1'b0, 1'b0);
        send(16'h0032, 2'b11, 1'b0, 1'b0, 1'b0);
        send(16'h0033, 2'b11, 1'b1, 1'b1, 1'b0);
        expect_word("t3pw0", 64'h0000_0000_0032_0031, 8'h0F, 1'b0, 1'b0, '0);
        expect_word("t3pw1", 64'h0000_0000_0000_0033, 8'h03, 1'b1, 1'b1, '0);

        // Output backpressure, including a tlast on every beat
        ready_pat = 20'b1011_0010_0110_1001_1100;
        fork
            begin
                for (int i = 0; i < 6; i++) send(16'(16'h61 + i), 2'b11, i == 5, 1'b0, 1'b0);
                for (int i = 0; i < 3; i++) send(16'(16'h71 + i), 2'b11, 1'b1, 1'b0, 1'b0);
            end
            begin
                for (int i = 0; i < 20; i++) begin
                    tx_if.tready = ready_pat[i];
                    idle(1);
                end
                tx_if.tready = 1'b1;
            end
        join
        expect_word("t4w0", 64'h0064_0063_0062_0061, 8'hFF, 1'b0, 1'b0, '0);
        expect_word("t4w1", 64'h0000_0000_0066_0065, 8'h0F, 1'b1, 1'b0, '0);
        expect_word("t4w2", 64'h0000_0000_0000_0071, 8'h03, 1'b1, 1'b0, '0);
        expect_word("t4w3", 64'h0000_0000_0000_0072, 8'h03, 1'b1, 1'b0, '0);
        expect_word("t4w4", 64'h0000_0000_0000_0073, 8'h03, 1'b1, 1'b0, '0);

        // Reset with a stalled output word and a partial word in the accumulator
        tx_if.tready = 1'b0;
        send(16'h0041, 2'b11, 1'b0, 1'b0, 1'b0);
        send(16'h0042, 2'b11, 1'b0, 1'b0, 1'b0);
        send(16'h0043, 2'b11, 1'b0, 1'b1, 1'b0);
        check_eq("t5.pre_valid", 128'(tx_if.tvalid), 128'(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t5.tvalid", 128'(tx_if.tvalid), 128'(1'b0));
        check_eq("t5.tdata",  128'(tx_if.tdata),  128'(64'h0));
        check_eq("t5.tkeep",  128'(tx_if.tkeep),  128'(8'h0));
        check_eq("t5.tlast",  128'(tx_if.tlast),  128'(1'b0));
        check_eq("t5.tid",    128'(tx_if.tid),    128'(1'b0));
        @(negedge clk);
        rst_n        = 1'b1;
        tx_if.tready = 1'b1;
        idle(1);
        check_eq("t5.none_emitted", 128'(got_q.size()), 128'(0));
        for (int i = 1; i <= 4; i++) send(16'(16'h50 + i), 2'b11, i == 4, 1'b0, 1'b0);
        expect_word("t5w0", 64'h0054_0053_0052_0051, 8'hFF, 1'b1, 1'b0, '0);

        // tuser handling
        send(16'h0081, 2'b11, 1'b0, 1'b0, 1'b1);
        send(16'h0082, 2'b11, 1'b0, 1'b0, 1'b0);
        send(16'h0083, 2'b11, 1'b0, 1'b0, 1'b1);
        send(16'h0084, 2'b11, 1'b1, 1'b0, 1'b1);
        expect_word("t6", 64'h0084_0083_0082_0081, 8'hFF, 1'b1, 1'b0, T6_USER);

        idle(5);
        check_eq("no_extra_words", 128'(got_q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
